alu4_cmd_sequencer: RTL and testbench
=====================================

// Module: alu4_cmd_sequencer
// PURPOSE
//  Upstream command stage for the 4-bit add/subtract/hold/clear unit.
//  Buffers operation commands in a FIFO and drives the unit's A, B, MODO, ENB and RCI.
//  Holds ENB high for a programmed number of clocks, then captures Q/RCO as a result
//  with a one-cycle valid pulse. Replaces hand-written stimulus sequences in system use.
// PARAMETERS
//  W      4  operand/result width; matches the 4-bit unit
//  DEPTH  4  command FIFO entries; power of 2, >=2
//  CYC_W  4  width of the per-command ENB-cycle count
// PORTS
//  CLK        in   1      clock; all logic on rising edge
//  RESET_L    in   1      reset; synchronous, active-low
//  CMD_VALID  in   1      command present
//  CMD_READY  out  1      FIFO can accept; =!full, forced 0 while RESET_L=0
//  CMD_A      in   W      operand A
//  CMD_B      in   W      operand B
//  CMD_MODO   in   2      00 hold, 01 add, 10 subtract, 11 clear
//  CMD_RCI    in   1      carry/borrow in
//  CMD_CYC    in   CYC_W  ENB-high clocks; 0 is treated as 1
//  A, B       out  W      to unit, registered
//  MODO       out  2      to unit, registered
//  ENB        out  1      to unit, registered
//  RCI        out  1      to unit, registered
//  Q          in   W      from unit; registered result
//  RCO        in   1      from unit
//  RES_Q      out  W      captured result
//  RES_RCO    out  1      captured carry
//  RES_VALID  out  1      one-cycle pulse; RES_Q/RES_RCO valid in that cycle
//  BUSY       out  1      FSM not in IDLE
//  OVF_CNT    out  8      only with SEQ_OVF_CNT_EN
// BEHAVIOUR
//  Reset (RESET_L=0 at an edge): applies from any state, including mid-ISSUE.
//   - FIFO flushed; state IDLE.
//   - A=B=0, MODO=00, ENB=0, RCI=0.
//   - RES_Q=0, RES_RCO=0, RES_VALID=0, BUSY=0, OVF_CNT=0.
//  Push: CMD_VALID&CMD_READY at an edge writes {A,B,MODO,RCI,CYC}.
//   - No push when full; no bypass, even if a pop occurs in the same edge.
//   - A push into an empty FIFO is visible for pop at the next edge.
//  FSM IDLE->ISSUE->CAPTURE->IDLE:
//   IDLE:    if FIFO not empty, at the edge:
//            - pop; load A,B,MODO,RCI; ENB<=1; cnt<=max(CYC,1)-1; ->ISSUE.
//   ISSUE:   ENB=1. Outputs are stable for the whole command.
//            - The unit updates Q at each ISSUE edge.
//            - If cnt==0: ENB<=0, MODO<=00 (hold), ->CAPTURE.
//            - Else: cnt<=cnt-1.
//   CAPTURE: ENB=0. At the edge: RES_Q<=Q, RES_RCO<=RCO, RES_VALID<=1, ->IDLE.
//  RES_VALID is high only in the cycle after CAPTURE.
//   - The next pop may occur in that same cycle; back-to-back commands are allowed.
//  Latency: pop edge to RES_VALID high = max(CYC,1)+2 edges.
//  A and B keep their last value after a command; ENB=0 whenever not in ISSUE.
//  The unit's arithmetic (wrap, carry, borrow) belongs to the unit; this block never alters Q.
//  RES_Q/RES_RCO hold their value until the next capture.
//  BUSY=1 in ISSUE and CAPTURE.
// CONFIGURATION
//  SEQ_OVF_CNT_EN defined:
//   - Port OVF_CNT exists.
//   - +1 per capture with RCO=1; saturates at 8'hFF; cleared only by reset.
//  Undefined: port OVF_CNT and its counter are absent; all other behaviour identical.
// TESTING
//  1. CMD A=2,B=1,MODO=01,RCI=0,CYC=1
//     -> ENB high 1 clk with A=2,B=1; RES_Q=3, RES_RCO=0, RES_VALID 1 clk, 3 edges after pop.
//  2. CMD A=4,B=1,MODO=10,CYC=0
//     -> ENB high exactly 1 clk (CYC=0 treated as 1); RES_Q=3.
//  3. CMD A=8,B=8,MODO=01
//     -> RES_Q=0, RES_RCO=1; OVF_CNT=1 with SEQ_OVF_CNT_EN.
//  4. First CMD CYC=15, then CMD_VALID held high
//     -> exactly 5 commands accepted; CMD_READY=0 until the first pop after the first completes.
//  5. RESET_L=0 for 1 edge mid-ISSUE, with 3 commands queued
//     -> ENB=0, MODO=00, BUSY=0, FIFO empty, no RES_VALID afterwards.
//  6. CMD MODO=11 followed by MODO=00, CYC=3
//     -> RES_Q=0 for both; ENB high 1 clk then 3 clks.

Source files
------------

// File: rtl/alu4_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu4_cmd_sequencer_if
// Command and result channels of the 4-bit unit command sequencer.
// The master issues commands and consumes results; the slave (the sequencer)
// accepts commands and produces results.
// ---------------------------------------------------------------------------
interface alu4_cmd_sequencer_if #(
    parameter int W     = 4,
    parameter int CYC_W = 4
);
    // Command channel: valid/ready handshake carrying one operation.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic [1:0]       cmd_modo;
    logic             cmd_rci;
    logic [CYC_W-1:0] cmd_cyc;

    // Result channel: one-cycle valid pulse, data held until the next capture.
    logic [W-1:0]     res_q;
    logic             res_rco;
    logic             res_valid;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_modo, cmd_rci, cmd_cyc,
        input  cmd_ready, res_q, res_rco, res_valid
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_modo, cmd_rci, cmd_cyc,
        output cmd_ready, res_q, res_rco, res_valid
    );
endinterface

// File: rtl/alu4_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu4_cmd_sequencer
// Upstream command stage for the 4-bit add/subtract/hold/clear unit.
// Commands are buffered in a small FIFO, then replayed to the unit: operands
// and mode are registered onto A/B/MODO/RCI, ENB is held high for the
// programmed number of clocks, and the unit's Q/RCO are captured as a result
// with a one-cycle RES_VALID pulse.
//
// Optional feature: define SEQ_OVF_CNT_EN to add the OVF_CNT port, a
// saturating count of captures whose RCO was 1.
//
// Reset is synchronous and active-low (reset_l).
// ---------------------------------------------------------------------------
module alu4_cmd_sequencer #(
    parameter int W     = 4,   // operand/result width of the unit
    parameter int DEPTH = 4,   // command FIFO entries, power of 2, >= 2
    parameter int CYC_W = 4    // width of the per-command ENB-cycle count
) (
    input  logic                 clk,
    input  logic                 reset_l,
    alu4_cmd_sequencer_if.slave  cmd_if,
    // Drive side of the 4-bit unit
    output logic [W-1:0]         a,
    output logic [W-1:0]         b,
    output logic [1:0]           modo,
    output logic                 enb,
    output logic                 rci,
    // Return side of the 4-bit unit
    input  logic [W-1:0]         q,
    input  logic                 rco,
    // Status
    output logic                 busy
`ifdef SEQ_OVF_CNT_EN
    ,
    output logic [7:0]           ovf_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] MODO_HOLD = 2'b00;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [1:0]       modo;
        logic             rci;
        logic [CYC_W-1:0] cyc;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    cmd_t             wr_entry;
    cmd_t             head;

    state_t           state;
    logic [CYC_W-1:0] cnt;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Ready is suppressed during reset so nothing is accepted on the flush edge.
    assign cmd_if.cmd_ready = reset_l & ~full;

    // Push is judged on the pre-edge fill level: a pop on the same edge does
    // not make room for a push into a full FIFO.
    assign push = cmd_if.cmd_valid & cmd_if.cmd_ready;

    // The sequencer pops only from IDLE; an entry written at an edge is seen
    // here from the following cycle, so there is no write-to-pop bypass.
    assign pop  = (state == S_IDLE) & ~empty;

    assign wr_entry = '{
        a:    cmd_if.cmd_a,
        b:    cmd_if.cmd_b,
        modo: cmd_if.cmd_modo,
        rci:  cmd_if.cmd_rci,
        cyc:  cmd_if.cmd_cyc
    };

    assign head = mem[rd_ptr];

    // Write the FIFO storage on an accepted command.
    // NOTE: the storage array has no reset; count and pointers decide which
    // entries are live, so stale contents are never read and the array can
    // map onto plain RAM cells without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Track pointers and fill level; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM: IDLE -> ISSUE -> CAPTURE -> IDLE, all outputs registered.
    // -----------------------------------------------------------------------
    // Sequence one command: load the unit, hold ENB, then capture Q/RCO.
    // NOTE: all sequential state is assigned with <= so every register in
    // this block sees pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state            <= S_IDLE;
            cnt              <= '0;
            a                <= '0;
            b                <= '0;
            modo             <= MODO_HOLD;
            enb              <= 1'b0;
            rci              <= 1'b0;
            busy             <= 1'b0;
            cmd_if.res_q     <= '0;
            cmd_if.res_rco   <= 1'b0;
            cmd_if.res_valid <= 1'b0;
        end else begin
            // The result pulse lasts exactly one cycle.
            cmd_if.res_valid <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        a     <= head.a;
                        b     <= head.b;
                        modo  <= head.modo;
                        rci   <= head.rci;
                        enb   <= 1'b1;
                        busy  <= 1'b1;
                        // A programmed count of 0 runs the unit for one clock.
                        cnt   <= (head.cyc == '0) ? '0 : head.cyc - CYC_W'(1);
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // A/B/MODO/RCI stay put for the whole command; the unit
                    // updates Q on every edge of this state.
                    if (cnt == '0) begin
                        enb   <= 1'b0;
                        modo  <= MODO_HOLD;
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt - CYC_W'(1);
                    end
                end

                S_CAPTURE: begin
                    // Unit is disabled and in hold, so Q/RCO are stable here.
                    cmd_if.res_q     <= q;
                    cmd_if.res_rco   <= rco;
                    cmd_if.res_valid <= 1'b1;
                    busy             <= 1'b0;
                    state            <= S_IDLE;
                end

                default: begin
                    enb   <= 1'b0;
                    modo  <= MODO_HOLD;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Optional carry/borrow-out event counter
    // -----------------------------------------------------------------------
`ifdef SEQ_OVF_CNT_EN
    // Count captures that return RCO=1, saturating at 8'hFF.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            ovf_cnt <= '0;
        end else if ((state == S_CAPTURE) && rco && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`else
    // Without SEQ_OVF_CNT_EN there is no counter and no OVF_CNT port.
`endif

endmodule

// File: tb/tb_alu4_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu4_cmd_sequencer
// Self-checking bench for alu4_cmd_sequencer. A behavioural 4-bit unit sits on
// the drive side; expected results come from a reference model that applies
// each command's operation to the previous unit state with integer
// arithmetic. Define SEQ_OVF_CNT_EN to also check OVF_CNT.
// ---------------------------------------------------------------------------
module tb_alu4_cmd_sequencer;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CYC_W = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] modo;
        logic       rci;
        logic [3:0] cyc;
    } cmd_t;

    // One observed command: what the unit was driven with and what came back.
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] modo;
        logic       rci;
        int         len;      // ENB-high cycles
        int         start;    // cycle of first ENB-high sample
        int         res_cyc;  // cycle of the RES_VALID sample
        bit         stable;   // A/B/MODO/RCI unchanged while ENB high
        logic [3:0] q;
        logic       rco;
    } obs_t;

    logic         clk     = 1'b0;
    logic         reset_l = 1'b0;
    logic [W-1:0] a, b;
    logic [1:0]   modo;
    logic         enb, rci, busy;
    logic [W-1:0] q   = '0;
    logic         rco = 1'b0;
`ifdef SEQ_OVF_CNT_EN
    logic [7:0]   ovf_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] model_prev = 5'd0;   // {rco,q} the unit holds between commands
    int         exp_ovf    = 0;

    alu4_cmd_sequencer_if #(.W(W), .CYC_W(CYC_W)) cmd_if ();

    alu4_cmd_sequencer #(.W(W), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .cmd_if  (cmd_if),
        .a       (a),
        .b       (b),
        .modo    (modo),
        .enb     (enb),
        .rci     (rci),
        .q       (q),
        .rco     (rco),
        .busy    (busy)
`ifdef SEQ_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit unit: registered Q/RCO, updated on edges with ENB=1.
    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b01: {rco, q} <= {1'b0, a} + {1'b0, b} + {4'd0, rci};
                2'b10: begin
                    q   <= a - b - {3'd0, rci};
                    rco <= ({1'b0, a} < ({1'b0, b} + {4'd0, rci}));
                end
                2'b11: begin
                    q   <= '0;
                    rco <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Reference: result of one command given the unit state before it.
    function automatic logic [4:0] ref_result(input cmd_t c, input logic [4:0] prev);
        int s;
        case (c.modo)
            2'd0: return prev;
            2'd1: begin
                s = int'(c.a) + int'(c.b) + int'(c.rci);
                return {(s > 15), 4'(s % 16)};
            end
            2'd2: begin
                s = int'(c.a) - int'(c.b) - int'(c.rci);
                return {(s < 0), 4'((s + 16) % 16)};
            end
            default: return 5'd0;
        endcase
    endfunction

    function automatic int enb_len(input cmd_t c);
        return (c.cyc == 4'd0) ? 1 : int'(c.cyc);
    endfunction

    function automatic cmd_t mk(input int a_, input int b_, input int m, input int r, input int c);
        cmd_t x;
        x.a = 4'(a_); x.b = 4'(b_); x.modo = 2'(m); x.rci = 1'(r); x.cyc = 4'(c);
        return x;
    endfunction

    function automatic cmd_t rand_cmd(input int max_cyc);
        return mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, max_cyc));
    endfunction

    function automatic void note_ovf(input logic [4:0] r);
        if (r[4] && exp_ovf < 255) exp_ovf++;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: record each command's ENB window and its captured result.
    // ---------------------------------------------------------------------
    obs_t       obs_q[$];
    obs_t       cur;
    int         cyc_no    = 0;
    bit         in_cmd    = 1'b0;
    int         pulse_err = 0;
    int         hold_err  = 0;
    logic       last_rv   = 1'b0;
    logic [4:0] last_res  = '0;
    bit         prev_rst  = 1'b0;

    always @(negedge clk) begin
        cyc_no++;
        if (!reset_l) begin
            in_cmd = 1'b0;
        end else begin
            if (enb) begin
                if (!in_cmd) begin
                    in_cmd = 1'b1;
                    cur.a = a; cur.b = b; cur.modo = modo; cur.rci = rci;
                    cur.len = 1; cur.start = cyc_no; cur.stable = 1'b1;
                end else begin
                    cur.len++;
                    if ({a, b, modo, rci} !== {cur.a, cur.b, cur.modo, cur.rci}) cur.stable = 1'b0;
                end
            end
            if (cmd_if.res_valid) begin
                cur.res_cyc = cyc_no;
                cur.q       = cmd_if.res_q;
                cur.rco     = cmd_if.res_rco;
                obs_q.push_back(cur);
                in_cmd = 1'b0;
            end
            if (cmd_if.res_valid && last_rv) pulse_err++;
            if (prev_rst && !cmd_if.res_valid && ({cmd_if.res_rco, cmd_if.res_q} !== last_res)) hold_err++;
        end
        prev_rst = reset_l;
        last_rv  = cmd_if.res_valid;
        last_res = {cmd_if.res_rco, cmd_if.res_q};
    end

    // ---------------------------------------------------------------------
    // Stimulus / collection helpers (no comparisons inside)
    // ---------------------------------------------------------------------
    task automatic set_fields(input cmd_t c);
        cmd_if.cmd_a    = c.a;
        cmd_if.cmd_b    = c.b;
        cmd_if.cmd_modo = c.modo;
        cmd_if.cmd_rci  = c.rci;
        cmd_if.cmd_cyc  = c.cyc;
    endtask

    task automatic drive_cmd(input cmd_t c, output bit ok);
        int n = 0;
        @(negedge clk);
        set_fields(c);
        cmd_if.cmd_valid = 1'b1;
        while (!cmd_if.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_if.cmd_ready;
        if (!ok) cmd_if.cmd_valid = 1'b0;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_result(output obs_t r, output bit got);
        int n = 0;
        while (obs_q.size() == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        got = (obs_q.size() != 0);
        if (got) r = obs_q.pop_front();
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b want=0", cmd_if.cmd_ready); end
        n_checks++; if ({a, b, modo, enb, rci} !== 12'd0) begin n_fail++; $display("FAIL rst_unit_drive got=%h want=000", {a, b, modo, enb, rci}); end
        n_checks++; if ({cmd_if.res_q, cmd_if.res_rco, cmd_if.res_valid, busy} !== 7'd0) begin n_fail++; $display("FAIL rst_result got=%h want=00", {cmd_if.res_q, cmd_if.res_rco, cmd_if.res_valid, busy}); end
`ifdef SEQ_OVF_CNT_EN
        n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_ovf got=%0d want=0", ovf_cnt); end
`endif
        @(posedge clk);
        #1 reset_l = 1'b1;
        @(negedge clk);
        n_checks++; if ({cmd_if.cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL post_rst_ready_busy got=%b want=10", {cmd_if.cmd_ready, busy}); end
    endtask

    task automatic test_add();
        obs_t r; bit ok, got; logic [4:0] e;
        cmd_t c = mk(2, 1, 1, 0, 1);
        drive_cmd(c, ok);
        wait_result(r, got);
        e = ref_result(c, model_prev); model_prev = e; note_ovf(e);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL add_timeout got=%b want=1", got); end
        n_checks++; if ({r.rco, r.q} !== e) begin n_fail++; $display("FAIL add_result got=%h want=%h", {r.rco, r.q}, e); end
        n_checks++; if (r.len !== 1) begin n_fail++; $display("FAIL add_enb_len got=%0d want=1", r.len); end
        // First ENB sample to RES_VALID sample is N+1 cycles (pop edge counted: N+2 edges).
        n_checks++; if (r.res_cyc - r.start !== 2) begin n_fail++; $display("FAIL add_latency got=%0d want=2", r.res_cyc - r.start); end
        n_checks++; if ({r.a, r.b, r.stable} !== {4'd2, 4'd1, 1'b1}) begin n_fail++; $display("FAIL add_operands got=%h want=%h", {r.a, r.b, r.stable}, {4'd2, 4'd1, 1'b1}); end
        @(negedge clk);
        // After the pulse: A/B retained, MODO back to hold, idle, result held.
        n_checks++; if ({cmd_if.res_valid, enb, busy, modo} !== 5'b0) begin n_fail++; $display("FAIL add_after_ctrl got=%b want=00000", {cmd_if.res_valid, enb, busy, modo}); end
        n_checks++; if ({a, b, cmd_if.res_q} !== {4'd2, 4'd1, 4'd3}) begin n_fail++; $display("FAIL add_after_hold got=%h want=213", {a, b, cmd_if.res_q}); end
    endtask

    task automatic test_sub_cyc0();
        obs_t r; bit ok, got; logic [4:0] e;
        cmd_t c = mk(4, 1, 2, 0, 0);
        drive_cmd(c, ok);
        wait_result(r, got);
        e = ref_result(c, model_prev); model_prev = e; note_ovf(e);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL sub_timeout got=%b want=1", got); end
        n_checks++; if ({r.rco, r.q} !== e) begin n_fail++; $display("FAIL sub_result got=%h want=%h", {r.rco, r.q}, e); end
        n_checks++; if (r.len !== 1) begin n_fail++; $display("FAIL sub_cyc0_enb_len got=%0d want=1", r.len); end
    endtask

    task automatic test_carry();
        obs_t r; bit ok, got; logic [4:0] e;
        cmd_t c = mk(8, 8, 1, 0, 1);
        drive_cmd(c, ok);
        wait_result(r, got);
        e = ref_result(c, model_prev); model_prev = e; note_ovf(e);
        n_checks++; if ({got, r.rco, r.q} !== {1'b1, e}) begin n_fail++; $display("FAIL carry_result got=%h want=%h", {got, r.rco, r.q}, {1'b1, e}); end
`ifdef SEQ_OVF_CNT_EN
        @(negedge clk);
        n_checks++; if (ovf_cnt !== 8'(exp_ovf)) begin n_fail++; $display("FAIL carry_ovf got=%0d want=%0d", ovf_cnt, exp_ovf); end
`endif
    endtask

    task automatic test_fifo_full();
        cmd_t cmds[$]; obs_t r, prev_r; bit got, rdy; int accepted = 0; int n = 0; logic [4:0] e;
        cmd_t c = rand_cmd(3);
        c.cyc = 4'd15;
        @(negedge clk);
        set_fields(c);
        cmd_if.cmd_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rdy = cmd_if.cmd_ready;
            if (i == 8) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got=%b want=1", busy); end
            end
            @(posedge clk);
            if (rdy) begin
                cmds.push_back(c);
                accepted++;
                c = rand_cmd(3);
            end
            #1 set_fields(c);
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
        n_checks++; if (accepted !== 5) begin n_fail++; $display("FAIL full_accepted got=%0d want=5", accepted); end
        // Ready returns only once the long command has completed and the next pops.
        while (!cmd_if.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if ({cmd_if.cmd_ready, 32'(obs_q.size())} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL full_reopen got=ready%b/done%0d want=ready1/done1", cmd_if.cmd_ready, obs_q.size()); end
        for (int i = 0; i < cmds.size(); i++) begin
            wait_result(r, got);
            e = ref_result(cmds[i], model_prev); model_prev = e; note_ovf(e);
            n_checks++; if ({got, r.rco, r.q} !== {1'b1, e}) begin n_fail++; $display("FAIL full_result[%0d] got=%h want=%h", i, {got, r.rco, r.q}, {1'b1, e}); end
            n_checks++; if (r.len !== enb_len(cmds[i])) begin n_fail++; $display("FAIL full_enb_len[%0d] got=%0d want=%0d", i, r.len, enb_len(cmds[i])); end
            if (i > 0) begin
                n_checks++; if (r.start !== prev_r.res_cyc + 1) begin n_fail++; $display("FAIL back_to_back[%0d] got=%0d want=%0d", i, r.start, prev_r.res_cyc + 1); end
            end
            prev_r = r;
        end
    endtask

    task automatic test_reset_mid_issue();
        bit ok; int enb_seen = 0;
        drive_cmd(mk(3, 5, 1, 1, 10), ok);
        for (int i = 0; i < 3; i++) drive_cmd(rand_cmd(3), ok);
        @(negedge clk);
        n_checks++; if ({enb, busy} !== 2'b11) begin n_fail++; $display("FAIL mid_issue_pre got=%b want=11", {enb, busy}); end
        @(posedge clk);
        #1 reset_l = 1'b0;
        @(posedge clk);
        #1 reset_l = 1'b1;
        @(negedge clk);
        n_checks++; if ({enb, modo, busy, cmd_if.res_valid} !== 5'b0) begin n_fail++; $display("FAIL mid_rst_outputs got=%b want=00000", {enb, modo, busy, cmd_if.res_valid}); end
`ifdef SEQ_OVF_CNT_EN
        n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_ovf got=%0d want=0", ovf_cnt); end
`endif
        exp_ovf = 0;
        obs_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (enb) enb_seen++;
        end
        n_checks++; if (enb_seen !== 0) begin n_fail++; $display("FAIL mid_rst_fifo_flushed got=%0d want=0", enb_seen); end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL mid_rst_no_result got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_clear_hold();
        obs_t r; bit ok, got; logic [4:0] e;
        cmd_t c1 = mk($urandom_range(0, 15), $urandom_range(0, 15), 3, $urandom_range(0, 1), 1);
        cmd_t c2 = mk($urandom_range(0, 15), $urandom_range(0, 15), 0, $urandom_range(0, 1), 3);
        drive_cmd(c1, ok);
        drive_cmd(c2, ok);
        // Unit state was unknown after the aborted command; clear defines it.
        wait_result(r, got);
        e = ref_result(c1, 5'd0); model_prev = e;
        n_checks++; if ({got, r.rco, r.q, r.len} !== {1'b1, e, 32'd1}) begin n_fail++; $display("FAIL clear got=%h/len%0d want=%h/len1", {r.rco, r.q}, r.len, e); end
        wait_result(r, got);
        e = ref_result(c2, model_prev); model_prev = e;
        n_checks++; if ({got, r.rco, r.q, r.len} !== {1'b1, e, 32'd3}) begin n_fail++; $display("FAIL hold got=%h/len%0d want=%h/len3", {r.rco, r.q}, r.len, e); end
    endtask

    task automatic test_random();
        cmd_t cmds[$]; obs_t r; bit ok, got; logic [4:0] e; cmd_t c;
        for (int i = 0; i < 24; i++) begin
            c = rand_cmd(6);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_cmd(c, ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_push[%0d] got=%b want=1", i, ok); end
            cmds.push_back(c);
        end
        for (int i = 0; i < cmds.size(); i++) begin
            wait_result(r, got);
            e = ref_result(cmds[i], model_prev); model_prev = e; note_ovf(e);
            n_checks++; if ({got, r.rco, r.q} !== {1'b1, e}) begin n_fail++; $display("FAIL rand_result[%0d] got=%h want=%h", i, {got, r.rco, r.q}, {1'b1, e}); end
            n_checks++; if (r.len !== enb_len(cmds[i])) begin n_fail++; $display("FAIL rand_enb_len[%0d] got=%0d want=%0d", i, r.len, enb_len(cmds[i])); end
            n_checks++; if (r.res_cyc - r.start !== enb_len(cmds[i]) + 1) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, r.res_cyc - r.start, enb_len(cmds[i]) + 1); end
            n_checks++; if ({r.a, r.b, r.modo, r.rci, r.stable} !== {cmds[i].a, cmds[i].b, cmds[i].modo, cmds[i].rci, 1'b1}) begin n_fail++; $display("FAIL rand_drive[%0d] got=%h want=%h", i, {r.a, r.b, r.modo, r.rci, r.stable}, {cmds[i].a, cmds[i].b, cmds[i].modo, cmds[i].rci, 1'b1}); end
        end
    endtask

    task automatic test_final();
        repeat (4) @(negedge clk);
        n_checks++; if (pulse_err !== 0) begin n_fail++; $display("FAIL res_valid_pulse_width got=%0d want=0", pulse_err); end
        n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL result_held got=%0d want=0", hold_err); end
        n_checks++; if ({busy, enb} !== 2'b00) begin n_fail++; $display("FAIL final_idle got=%b want=00", {busy, enb}); end
`ifdef SEQ_OVF_CNT_EN
        n_checks++; if (ovf_cnt !== 8'(exp_ovf)) begin n_fail++; $display("FAIL final_ovf got=%0d want=%0d", ovf_cnt, exp_ovf); end
`endif
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        set_fields('0);
        test_reset();
        test_add();
        test_sub_cyc0();
        test_carry();
        test_fifo_full();
        test_reset_mid_issue();
        test_clear_hold();
        test_random();
        test_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d cycles", cyc_no);
        $fatal(1, "simulation did not finish");
    end

endmodule
